// File: rtl/prbs_gen_par_if.sv
// Handshake/data bundle for the parallel PRBS generator.
// The master drives control and seed; the slave returns the PRBS word and its valid flag.
interface prbs_gen_par_if #(
   parameter int unsigned W = 8
);
   logic          trig_en;
   logic          seed_load;
   logic [2:0]    prbs_mode;
   logic [30:0]   seed_in;
   logic          err_inj;
   logic [W-1:0]  prbs_out;
   logic          dout_valid;

   modport master (
      output trig_en, seed_load, prbs_mode, seed_in, err_inj,
      input  prbs_out, dout_valid
   );

   modport slave (
      input  trig_en, seed_load, prbs_mode, seed_in, err_inj,
      output prbs_out, dout_valid
   );
endinterface

// File: rtl/prbs_gen_par.sv
// Parallel Fibonacci PRBS generator: W bits per enabled cycle, run-time selectable order
// (7/9/15/23/31), seed load with lock-up protection, and single-shot bit-0 error injection.
module prbs_gen_par #(
   parameter int unsigned W            = 8,
   parameter int unsigned MODE_DEFAULT = 2
) (
   input  logic           prbs_clk,
   input  logic           prbs_rst_n,
   prbs_gen_par_if.slave  bus
);
   localparam int unsigned SW = 31;

   logic [SW-1:0] lfsr_r;
   logic [2:0]    mode_r;
   logic          err_pend_r;

   logic [SW-1:0] step_c;
   logic [W-1:0]  word_c;
   logic [SW-1:0] seed_c;
   logic          err_now_c;

   // Register length n for a mode; unsupported codes fall back to PRBS15.
   function automatic logic [4:0] order_n(input logic [2:0] m);
      case (m)
         3'd0:    order_n = 5'd7;
         3'd1:    order_n = 5'd9;
         3'd3:    order_n = 5'd23;
         3'd4:    order_n = 5'd31;
         default: order_n = 5'd15;
      endcase
   endfunction

   // Second feedback tap k for a mode.
   function automatic logic [4:0] tap_k(input logic [2:0] m);
      case (m)
         3'd0:    tap_k = 5'd6;
         3'd1:    tap_k = 5'd5;
         3'd3:    tap_k = 5'd18;
         3'd4:    tap_k = 5'd28;
         default: tap_k = 5'd14;
      endcase
   endfunction

   // W serial steps unrolled; bits of the state above n-1 never reach a tap.
   always_comb begin
      logic [SW-1:0] s;
      logic [4:0]    n;
      logic [4:0]    k;
      logic          fb;
      s      = lfsr_r;
      n      = order_n(mode_r);
      k      = tap_k(mode_r);
      fb     = 1'b0;
      word_c = '0;
      for (int unsigned i = 0; i < W; i++) begin
         fb                = s[n - 5'd1] ^ s[k - 5'd1];
         word_c[W - 1 - i] = fb;
         s                 = {s[SW-2:0], fb};
      end
      step_c = s;
   end

   // Seed as loaded, replaced by all ones when its low n bits are zero.
   always_comb begin
      logic [4:0]    ln;
      logic [SW-1:0] mask;
      ln     = order_n(bus.prbs_mode);
      mask   = (SW'(1) << ln) - SW'(1);
      seed_c = ((bus.seed_in & mask) == '0) ? '1 : bus.seed_in;
   end

   assign err_now_c = err_pend_r | bus.err_inj;

   always_ff @(posedge prbs_clk or negedge prbs_rst_n) begin
      if (!prbs_rst_n) begin
         lfsr_r         <= '1;
         mode_r         <= 3'(MODE_DEFAULT);
         err_pend_r     <= 1'b0;
         bus.prbs_out   <= '0;
         bus.dout_valid <= 1'b0;
      end else if (bus.seed_load) begin
         lfsr_r         <= seed_c;
         mode_r         <= bus.prbs_mode;
         err_pend_r     <= err_now_c;
         bus.dout_valid <= 1'b0;
      end else if (bus.trig_en) begin
         lfsr_r         <= step_c;
         err_pend_r     <= 1'b0;
         bus.prbs_out   <= word_c ^ W'(err_now_c);
         bus.dout_valid <= 1'b1;
      end else begin
         err_pend_r     <= err_now_c;
         bus.dout_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_prbs_gen_par.sv
// Directed bench for prbs_gen_par: W=8 stream checks plus a W=1 instance for period checks.
module tb_prbs_gen_par;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   prbs_gen_par_if #(.W(8)) if8 ();
   prbs_gen_par_if #(.W(1)) if1 ();

   prbs_gen_par #(.W(8), .MODE_DEFAULT(2)) dut  (.prbs_clk(clk), .prbs_rst_n(rst_n), .bus(if8));
   prbs_gen_par #(.W(1), .MODE_DEFAULT(2)) dut1 (.prbs_clk(clk), .prbs_rst_n(rst_n), .bus(if1));

   int checks = 0;
   int errors = 0;

   logic [30:0] ms;
   int unsigned mn;
   int unsigned mk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serial reference LFSR.
   task automatic m_load(input logic [2:0] mode, input logic [30:0] seed);
      logic [30:0] mask;
      case (mode)
         3'd0:    begin mn = 7;  mk = 6;  end
         3'd1:    begin mn = 9;  mk = 5;  end
         3'd3:    begin mn = 23; mk = 18; end
         3'd4:    begin mn = 31; mk = 28; end
         default: begin mn = 15; mk = 14; end
      endcase
      mask = 31'h7FFF_FFFF >> (31 - mn);
      ms   = ((seed & mask) == 31'd0) ? 31'h7FFF_FFFF : seed;
   endtask

   task automatic m_next(input int nb, output logic [31:0] w);
      logic fb;
      w = 32'd0;
      for (int i = 0; i < nb; i++) begin
         fb = ms[mn-1] ^ ms[mk-1];
         w  = {w[30:0], fb};
         ms = {ms[29:0], fb};
      end
   endtask

   task automatic word8(input string tag, input logic [31:0] flip, output logic [31:0] w);
      m_next(8, w);
      tick();
      check(tag, 32'(if8.prbs_out), (w ^ flip) & 32'hFF);
      check({tag, "_valid"}, 32'(if8.dout_valid), 32'd1);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic period_test(input string tag, input logic [2:0] mode, input logic [30:0] seed,
                              input int n, output logic [15:0] first16);
      logic [1023:0] hist;
      logic [31:0]   w;
      logic [30:0]   mask;
      int            p;
      int            rep_bad;
      int            mdl_bad;
      p    = (1 << n) - 1;
      mask = 31'h7FFF_FFFF >> (31 - n);
      hist = '0;
      if1.prbs_mode = mode;
      if1.seed_in   = seed;
      if1.seed_load = 1'b1;
      tick();
      if1.seed_load = 1'b0;
      if1.trig_en   = 1'b1;
      for (int i = 0; i < 2 * p; i++) begin
         tick();
         hist[i] = if1.prbs_out[0];
         if (i == p - 1)
            check({tag, "_state"}, 32'(dut1.lfsr_r & mask), 32'(seed & mask));
      end
      if1.trig_en = 1'b0;
      rep_bad = 0;
      for (int i = 0; i < p; i++)
         if (hist[i] !== hist[i + p]) rep_bad++;
      check({tag, "_repeat"}, 32'(rep_bad), 32'd0);
      m_load(mode, seed);
      mdl_bad = 0;
      for (int i = 0; i < p; i++) begin
         m_next(1, w);
         if (hist[i] !== w[0]) mdl_bad++;
      end
      check({tag, "_model"}, 32'(mdl_bad), 32'd0);
      for (int i = 0; i < 16; i++) first16[15 - i] = hist[i];
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] last;
      logic [15:0] f16;
      logic        tr;

      rst_n = 1'b0;
      if8.trig_en = 1'b0; if8.seed_load = 1'b0; if8.prbs_mode = 3'd0; if8.seed_in = '0; if8.err_inj = 1'b0;
      if1.trig_en = 1'b0; if1.seed_load = 1'b0; if1.prbs_mode = 3'd0; if1.seed_in = '0; if1.err_inj = 1'b0;
      #12;
      check("rst_out", 32'(if8.prbs_out), 32'd0);
      check("rst_valid", 32'(if8.dout_valid), 32'd0);
      rst_n = 1'b1;
      tick();

      // PRBS7 from all ones
      if8.seed_load = 1'b1; if8.prbs_mode = 3'd0; if8.seed_in = 31'h7F;
      tick();
      check("seed_valid", 32'(if8.dout_valid), 32'd0);
      if8.seed_load = 1'b0; if8.trig_en = 1'b1;
      tick();
      check("p7_w0", 32'(if8.prbs_out), 32'h02);
      tick();
      check("p7_w1", 32'(if8.prbs_out), 32'h0C);
      if8.trig_en = 1'b0;

      // Default PRBS15 after reset
      pulse_reset();
      if8.trig_en = 1'b1;
      tick();
      check("p15_w0", 32'(if8.prbs_out), 32'h00);
      check("p15_v0", 32'(if8.dout_valid), 32'd1);
      tick();
      check("p15_w1", 32'(if8.prbs_out), 32'h02);
      if8.trig_en = 1'b0;

      // Stall: 15 on, 2 off, 5 on against a gapless reference run
      pulse_reset();
      m_load(3'd2, 31'h7FFF);
      last = 32'd0;
      for (int c = 0; c < 22; c++) begin
         tr = (c < 15) || (c >= 17);
         if8.trig_en = tr;
         if (tr) begin
            word8("stall_word", 32'd0, w);
            last = w;
         end else begin
            tick();
            check("stall_gap_valid", 32'(if8.dout_valid), 32'd0);
            check("stall_gap_hold", 32'(if8.prbs_out), last & 32'hFF);
         end
      end

      // Error injection: two pulses during a stall count once
      if8.trig_en = 1'b0; if8.err_inj = 1'b1;
      tick();
      tick();
      if8.err_inj = 1'b0;
      check("err_gap_hold", 32'(if8.prbs_out), last & 32'hFF);
      if8.trig_en = 1'b1;
      word8("err_word", 32'd1, w);
      word8("err_after", 32'd0, w);
      if8.err_inj = 1'b1;
      word8("err_same_cycle", 32'd1, w);
      if8.err_inj = 1'b0;
      word8("err_same_after", 32'd0, w);

      // Zero seed loads all ones; seed_load beats trig_en
      if8.seed_load = 1'b1; if8.prbs_mode = 3'd2; if8.seed_in = 31'd0;
      tick();
      check("prio_valid", 32'(if8.dout_valid), 32'd0);
      if8.seed_load = 1'b0;
      tick();
      check("zseed_w0", 32'(if8.prbs_out), 32'h00);
      tick();
      check("zseed_w1", 32'(if8.prbs_out), 32'h02);
      m_load(3'd2, 31'd0);
      m_next(16, w);
      word8("zseed_w2", 32'd0, w);

      // Mode code 5 behaves as PRBS15
      if8.trig_en = 1'b0;
      if8.seed_load = 1'b1; if8.prbs_mode = 3'd5; if8.seed_in = 31'h1234;
      tick();
      if8.seed_load = 1'b0; if8.trig_en = 1'b1;
      m_load(3'd2, 31'h1234);
      word8("mode5_w0", 32'd0, w);
      word8("mode5_w1", 32'd0, w);

      // Async reset between edges, then restart in PRBS15
      if8.seed_load = 1'b1; if8.prbs_mode = 3'd3; if8.seed_in = 31'h5A5A5;
      tick();
      if8.seed_load = 1'b0;
      tick();
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_out", 32'(if8.prbs_out), 32'd0);
      check("arst_valid", 32'(if8.dout_valid), 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      check("arst_w0", 32'(if8.prbs_out), 32'h00);
      tick();
      check("arst_w1", 32'(if8.prbs_out), 32'h02);
      if8.trig_en = 1'b0;

      // Period checks on the W=1 instance
      period_test("per7", 3'd0, 31'h7F, 7, f16);
      check("per7_first16", 32'(f16), 32'h020C);
      period_test("per9", 3'd1, 31'h1A5, 9, f16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $fatal(1, "FAIL timeout");
   end
endmodule
